// File: rtl/divider_pkg.sv
// Shared constants for the pipelined restoring divider.
// LATENCY is input-cycle to output-cycle distance: one input register plus one stage per quotient bit.
package divider_pkg;
  localparam int DEFAULT_WIDTH = 32;
  localparam int LATENCY       = DEFAULT_WIDTH + 1;

  function automatic int latency(input int width);
    return width + 1;
  endfunction
endpackage

// File: rtl/divider_if.sv
// Operand/result bundle for divider_pipelined; the master issues operands, the slave returns results.
// No ready signal: the divider accepts one operation every cycle.
interface divider_if #(
  parameter int width = 32
) ();
  logic             in_valid;
  logic [width-1:0] a;
  logic [width-1:0] b;
  logic             out_valid;
  logic [width-1:0] q;
  logic [width-1:0] r;
  logic             div_by_zero;

  modport master (
    output in_valid, a, b,
    input  out_valid, q, r, div_by_zero
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, q, r, div_by_zero
  );
endinterface

// File: rtl/divider_stage.sv
// One restoring-division step: resolves one quotient bit from the dividend MSB, then registers everything.
// Latency 1 cycle, no backpressure.
import divider_pkg::*;

module divider_stage #(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [width:0]   prev_rem,
  input  logic [width-1:0] prev_q,
  input  logic [width-1:0] prev_b,
  input  logic [width-1:0] prev_dvd,
  input  logic             prev_vld,
  input  logic             prev_dbz,
  output logic [width:0]   rem,
  output logic [width-1:0] q,
  output logic [width-1:0] b,
  output logic [width-1:0] dvd,
  output logic             vld,
  output logic             dbz
);
  logic [width:0] t;
  logic [width:0] diff;
  logic           ge;
  logic           unused_bits;

  // The partial remainder is always below b, so its top bit is zero and shifts out safely.
  always_comb begin
    t    = {prev_rem[width-1:0], prev_dvd[width-1]};
    diff = t - {1'b0, prev_b};
    ge   = (t >= {1'b0, prev_b});
  end

  assign unused_bits = prev_rem[width] ^ prev_q[width-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= '0;
      q   <= '0;
      b   <= '0;
      dvd <= '0;
      vld <= 1'b0;
      dbz <= 1'b0;
    end else begin
      rem <= ge ? diff : t;
      q   <= {prev_q[width-2:0], ge};
      b   <= prev_b;
      dvd <= {prev_dvd[width-2:0], 1'b0};
      vld <= prev_vld;
      dbz <= prev_dbz;
    end
  end
endmodule

// File: rtl/divider_pipelined.sv
// Fully pipelined unsigned restoring divider: q = a/b, r = a mod b, b == 0 gives q = all ones, r = a.
// Latency width+1 cycles, one op per cycle, no backpressure.
import divider_pkg::*;

module divider_pipelined #(
  parameter int width = DEFAULT_WIDTH
) (
  input  logic     clk,
  input  logic     rst_n,
  divider_if.slave io
);
  logic [width:0]   rem_p [0:width];
  logic [width-1:0] q_p   [0:width];
  logic [width-1:0] b_p   [0:width];
  logic [width-1:0] dvd_p [0:width];
  logic             vld_p [0:width];
  logic             dbz_p [0:width];

  logic [width-1:0] a_in;
  logic [width-1:0] b_in;
  logic             vld_in;
  logic             dbz_in;
  logic             unused_tail;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_in   <= '0;
      b_in   <= '0;
      vld_in <= 1'b0;
      dbz_in <= 1'b0;
    end else begin
      a_in   <= io.a;
      b_in   <= io.b;
      vld_in <= io.in_valid;
      dbz_in <= (io.b == '0);
    end
  end

  assign rem_p[0] = '0;
  assign q_p[0]   = '0;
  assign b_p[0]   = b_in;
  assign dvd_p[0] = a_in;
  assign vld_p[0] = vld_in;
  assign dbz_p[0] = dbz_in;

  // Stage k resolves quotient bit width-k.
  for (genvar k = 1; k <= width; k++) begin : g_stage
    divider_stage #(.width(width)) u_stage (
      .clk      (clk),
      .rst_n    (rst_n),
      .prev_rem (rem_p[k-1]),
      .prev_q   (q_p[k-1]),
      .prev_b   (b_p[k-1]),
      .prev_dvd (dvd_p[k-1]),
      .prev_vld (vld_p[k-1]),
      .prev_dbz (dbz_p[k-1]),
      .rem      (rem_p[k]),
      .q        (q_p[k]),
      .b        (b_p[k]),
      .dvd      (dvd_p[k]),
      .vld      (vld_p[k]),
      .dbz      (dbz_p[k])
    );
  end

  assign io.out_valid   = vld_p[width];
  assign io.q           = q_p[width];
  assign io.r           = rem_p[width][width-1:0];
  assign io.div_by_zero = dbz_p[width];

  assign unused_tail = ^{rem_p[width][width], b_p[width], dvd_p[width]};
endmodule

// File: tb/tb_divider_pipelined.sv
// Scoreboard bench for divider_pipelined at width 32 and width 8.
// Expected results are queued at issue and popped when out_valid appears.
module tb_divider_pipelined;
  import divider_pkg::*;

  localparam int W  = DEFAULT_WIDTH;
  localparam int W8 = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  divider_if #(.width(W))  bus  ();
  divider_if #(.width(W8)) bus8 ();

  divider_pipelined #(.width(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  divider_pipelined #(.width(W8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus8)
  );

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          issue;
  } exp_t;

  exp_t sb[$];
  exp_t sb8[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mask_of(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
  endfunction

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input int w);
    exp_t e;
    if (b == 32'd0) begin
      e.q   = mask_of(w);
      e.r   = a;
      e.dbz = 1'b1;
    end else begin
      e.q   = a / b;
      e.r   = a % b;
      e.dbz = 1'b0;
    end
    e.issue = 0;
    return e;
  endfunction

  // Roughly 10% divide-by-zero, 10% a < b, the rest with b of varying magnitude.
  task automatic gen(input int w, output logic [31:0] a, output logic [31:0] b);
    int          sel;
    logic [31:0] m;
    m   = mask_of(w);
    sel = $urandom_range(0, 9);
    a   = $urandom & m;
    if (sel == 0) begin
      b = 32'd0;
    end else if (sel == 1) begin
      b = ($urandom & m) | 32'd1;
      a = a % b;
    end else begin
      b = ($urandom & m) >> $urandom_range(0, w - 1);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edbz);
    exp_t e;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    e.q = eq; e.r = er; e.dbz = edbz; e.issue = cyc;
    sb.push_back(e);
    @(negedge clk);
  endtask

  task automatic issue_rand();
    logic [31:0] a, b;
    exp_t        e;
    gen(W, a, b);
    e = model(a, b, W);
    issue(a, b, e.q, e.r, e.dbz);
  endtask

  task automatic idle(input int n);
    bus.in_valid  = 1'b0;
    bus.a         = $urandom;
    bus.b         = $urandom;
    bus8.in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs();
    check("rst out_valid", bus.out_valid, 0);
    check("rst q", bus.q, 0);
    check("rst r", bus.r, 0);
    check("rst div_by_zero", bus.div_by_zero, 0);
    check("rst w8 out_valid", bus8.out_valid, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.out_valid) begin
      if (sb.size() == 0) begin
        check("w32 unexpected out_valid", bus.out_valid, 0);
      end else begin
        e = sb.pop_front();
        check("w32 q", bus.q, e.q);
        check("w32 r", bus.r, e.r);
        check("w32 div_by_zero", bus.div_by_zero, e.dbz);
        check("w32 latency", cyc - e.issue, LATENCY);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus8.out_valid) begin
      if (sb8.size() == 0) begin
        check("w8 unexpected out_valid", bus8.out_valid, 0);
      end else begin
        e = sb8.pop_front();
        check("w8 q", bus8.q, e.q);
        check("w8 r", bus8.r, e.r);
        check("w8 div_by_zero", bus8.div_by_zero, e.dbz);
        check("w8 latency", cyc - e.issue, latency(W8));
      end
    end
  end

  initial begin
    int          bub_pat [6];
    logic [31:0] a, b;
    exp_t        e;

    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus8.in_valid = 1'b0;
    bus8.a        = '0;
    bus8.b        = '0;
    bub_pat       = '{1, 0, 1, 0, 0, 1};

    repeat (3) @(negedge clk);
    check_reset_outputs();
    rst_n = 1'b1;
    idle(2);

    // single op
    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    idle(40);

    // back-to-back
    issue(32'hFFFF_FFFF, 32'd1,       32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(32'd5,         32'd9,       32'd0,         32'd5, 1'b0);
    issue(32'h8000_0000, 32'h1_0000,  32'h8000,      32'd0, 1'b0);
    issue(32'd12345678,  32'd12345678, 32'd1,        32'd0, 1'b0);
    idle(40);

    // divide by zero followed by a normal op
    issue(32'hDEAD_BEEF, 32'd0, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b1);
    issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    idle(40);

    // bubbles
    foreach (bub_pat[i]) begin
      if (bub_pat[i] != 0) issue_rand();
      else idle(1);
    end
    idle(40);

    // reset mid-flight: in-flight ops must vanish
    repeat (10) issue_rand();
    idle(4);
    #2;
    rst_n = 1'b0;
    sb.delete();
    sb8.delete();
    #1;
    check_reset_outputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(45);
    issue(32'd1000, 32'd33, 32'd30, 32'd10, 1'b0);
    idle(40);

    // random regression on both widths
    repeat (3000) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.in_valid  = 1'b0;
        bus8.in_valid = 1'b0;
      end else begin
        gen(W, a, b);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        e            = model(a, b, W);
        e.issue      = cyc;
        sb.push_back(e);

        gen(W8, a, b);
        bus8.in_valid = 1'b1;
        bus8.a        = a[W8-1:0];
        bus8.b        = b[W8-1:0];
        e             = model(a, b, W8);
        e.issue       = cyc;
        sb8.push_back(e);
      end
      @(negedge clk);
    end
    idle(50);

    check("w32 scoreboard drained", sb.size(), 0);
    check("w8 scoreboard drained", sb8.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
